sp_bram_client_ctrl: RTL and testbench
======================================

Name: sp_bram_client_ctrl

Overview:
- Initiator-side controller for the single-port byte-write BRAM used by the MRU cache (interface `re`, `we[DATA_WIDTH/8]`, `adr`, `wdat`, `rdat`; read has priority over write; 1-cycle read latency).
- Converts a valid/ready request stream into RAM port cycles.
- Absorbs RAM read latency into a 2-entry response FIFO so the consumer can backpressure via `rsp_ready`.
- After reset it walks the whole RAM writing `INIT_VALUE`, so cache tags/MRU state start clean.

Parameters:
- ADDR_WIDTH, 10, RAM address width; RAM depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8.
- INIT_EN, 1, 1 = run the clear sweep after reset; 0 = enter RUN directly.
- INIT_VALUE, 0, word written to every address during the clear sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- init_done  out  1  high once the clear sweep is complete (state RUN).
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_re  in  1  read request.
- req_we  in  DATA_WIDTH/8  byte write strobes.
- req_adr  in  ADDR_WIDTH  request address.
- req_wdat  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes read data.
- rsp_rdat  out  DATA_WIDTH  read data, in request order.
- ram_re  out  1  RAM read enable.
- ram_we  out  DATA_WIDTH/8  RAM byte write enables.
- ram_adr  out  ADDR_WIDTH  RAM address.
- ram_wdat  out  DATA_WIDTH  RAM write data.
- ram_rdat  in  DATA_WIDTH  RAM read data, valid the cycle after ram_re.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset values: init_done=0, req_ready=0, rsp_valid=0, rsp_rdat=0, FIFO count=0, inflight=0. While `rst` is high, ram_re=0, ram_we=0, ram_adr=0, ram_wdat=0.
- FSM states: INIT, RUN. Reset enters INIT if INIT_EN=1, otherwise RUN.
- INIT state:
  - Sweep counter starts at 0; each cycle it drives ram_we=all-ones, ram_adr=counter, ram_wdat=INIT_VALUE.
  - req_ready=0.
  - After address 2**ADDR_WIDTH-1 is written, go to RUN the next cycle; init_done=1 from that cycle. The sweep takes exactly 2**ADDR_WIDTH cycles.
- RAM drive in RUN is combinational from the accepted request (acc = req_valid&&req_ready):
  - ram_re = acc&&req_re.
  - ram_we = (acc&&!req_re) ? req_we : 0.
  - ram_adr = req_adr; ram_wdat = req_wdat.
- Priority:
  - req_re=1 with req_we!=0: read issued, write dropped (same as RAM priority).
  - req_re=0 with req_we=0: accepted as a no-op.
- Inflight flag:
  - Set the cycle after ram_re; that cycle ram_rdat is pushed into the FIFO.
  - rsp_valid rises 2 cycles after read acceptance (fixed minimum latency 2).
- Credit rule: req_ready = RUN && (count + inflight - (rsp_valid&&rsp_ready)) < 2.
  - The combinational path rsp_ready->req_ready is intended.
  - req_ready does not depend on req_re; writes stall under the same credit.
  - With rsp_ready held high, reads sustain 1 per cycle.
- Response FIFO:
  - Depth 2, registered outputs, order preserved.
  - Push and pop in the same cycle are allowed, including pop when count=2.
  - Overflow is impossible by the credit rule; a bench assertion checks push when count=2 && !pop.
- Write-then-read same address on consecutive cycles returns the new data (RAM ordering); the controller adds no forwarding.
- Reset mid-operation: FIFO and inflight are discarded, rsp_valid drops the next cycle, init_done=0, and the sweep restarts from address 0.

Decomposition:
- Package sp_bram_client_pkg:
  - state enum {INIT, RUN}.
  - localparam RSP_DEPTH=2.
  - function for strobe width (DATA_WIDTH/8).
- Sub-module sp_bram_rsp_fifo: 2-entry synchronous FIFO with push/pop/count/valid, sync reset; reused for other cache RAM clients.

Test Plan:
- Reset with INIT_EN=1, ADDR_WIDTH=4 -> 16 consecutive cycles ram_we=4'hF, adr 0..15, wdat=INIT_VALUE; init_done=1 in cycle 16; req_ready=0 throughout the sweep.
- Write adr 3 data 32'hA5A5_1234 strobes 4'b0101, then read adr 3 (RAM model preloaded 0) -> rsp_rdat=32'h00A5_0034 exactly 2 cycles after read acceptance.
- Back-to-back reads adr 0..7 with rsp_ready=1 -> req_ready stays 1, 8 responses on 8 consecutive cycles, in order.
- Reads with rsp_ready=0 -> exactly 2 reads accepted then req_ready=0; raising rsp_ready drains both in order, and req_ready returns in the same cycle.
- req_re=1 and req_we=4'hF at adr 5 -> ram_re=1, ram_we=0; RAM contents unchanged.
- Assert rst while 2 responses are pending -> rsp_valid=0 the next cycle, the sweep restarts at adr 0, and no stale response appears after init_done.

Source files
------------

// File: rtl/sp_bram_client_pkg.sv
// rtl/sp_bram_client_pkg.sv - shared types and constants for the BRAM client controller
package sp_bram_client_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int RSP_DEPTH = 2;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sp_bram_rsp_fifo.sv
// rtl/sp_bram_rsp_fifo.sv - 2-entry response FIFO with registered head, shared by cache RAM clients
module sp_bram_rsp_fifo
    import sp_bram_client_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] tail;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((count != 2'(RSP_DEPTH)) || do_pop);
    assign valid   = (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            data  <= '0;
            tail  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        data <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    data  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        data <= push_data;
                    end else begin
                        data <= tail;
                        tail <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sp_bram_client_ctrl.sv
// rtl/sp_bram_client_ctrl.sv - request/response front end for the MRU cache single-port BRAM
module sp_bram_client_ctrl
    import sp_bram_client_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    init_done,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_re,
    input  logic [DATA_WIDTH/8-1:0] req_we,
    input  logic [ADDR_WIDTH-1:0]   req_adr,
    input  logic [DATA_WIDTH-1:0]   req_wdat,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdat,
    output logic                    ram_re,
    output logic [DATA_WIDTH/8-1:0] ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_adr,
    output logic [DATA_WIDTH-1:0]   ram_wdat,
    input  logic [DATA_WIDTH-1:0]   ram_rdat
);

    localparam int                    STRB_W   = strb_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] sweep_adr;
    logic [ADDR_WIDTH-1:0] sweep_adr_next;
    logic                  inflight;
    logic [1:0]            count;
    logic                  pop;
    logic                  acc;
    logic                  run;
    logic [2:0]            occupancy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_EN ? INIT : RUN;
            sweep_adr <= '0;
            inflight  <= 1'b0;
        end else begin
            state     <= state_next;
            sweep_adr <= sweep_adr_next;
            inflight  <= ram_re;
        end
    end

    // Credit counts the read already in the RAM pipe, so the FIFO can never overflow.
    assign run       = (state == RUN) && !rst;
    assign pop       = rsp_valid && rsp_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign req_ready = run && (occupancy < 3'd2);
    assign acc       = req_valid && req_ready;
    assign init_done = run;

    always_comb begin
        state_next     = state;
        sweep_adr_next = sweep_adr;
        ram_re         = 1'b0;
        ram_we         = '0;
        ram_adr        = '0;
        ram_wdat       = '0;
        if (!rst) begin
            case (state)
                INIT: begin
                    ram_we         = {STRB_W{1'b1}};
                    ram_adr        = sweep_adr;
                    ram_wdat       = INIT_VALUE;
                    sweep_adr_next = sweep_adr + ADR_ONE;
                    if (sweep_adr == LAST_ADR) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    // A read with strobes set drops the write, matching the RAM's own priority.
                    ram_re   = acc && req_re;
                    ram_we   = (acc && !req_re) ? req_we : '0;
                    ram_adr  = req_adr;
                    ram_wdat = req_wdat;
                end
            endcase
        end
    end

    sp_bram_rsp_fifo #(
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(ram_rdat),
        .pop      (pop),
        .count    (count),
        .valid    (rsp_valid),
        .data     (rsp_rdat)
    );

endmodule

// File: tb/tb_sp_bram_client_ctrl.sv
// tb/tb_sp_bram_client_ctrl.sv - scoreboard bench for sp_bram_client_ctrl with a byte-write RAM model
module tb_sp_bram_client_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          req_valid;
    logic          req_ready;
    logic          req_re;
    logic [SW-1:0] req_we;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_wdat;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdat;
    logic          ram_re;
    logic [SW-1:0] ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_wdat;
    logic [DW-1:0] ram_rdat;

    sp_bram_client_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INIT_EN   (1'b1),
        .INIT_VALUE(32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .init_done(init_done),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_re   (req_re),
        .req_we   (req_we),
        .req_adr  (req_adr),
        .req_wdat (req_wdat),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdat (rsp_rdat),
        .ram_re   (ram_re),
        .ram_we   (ram_we),
        .ram_adr  (ram_adr),
        .ram_wdat (ram_wdat),
        .ram_rdat (ram_rdat)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (ram_re) begin
            ram_rdat <= mem[ram_adr];
        end else begin
            for (int b = 0; b < SW; b++) begin
                if (ram_we[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %0h required no response (cycle %0d)", rsp_rdat, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdat", 64'(rsp_rdat), 64'(e.data));
                if (e.due >= 0) check("rsp_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && dut.u_fifo.count == 2'd2 && dut.u_fifo.push && !dut.u_fifo.pop) begin
            checks++;
            errors++;
            $display("FAIL fifo_overflow: got push at count 2 required no push (cycle %0d)", cyc);
        end
    end

    task automatic send(input logic re, input logic [SW-1:0] we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] wdat, input logic [DW-1:0] exp_data,
                        input bit timed, output int waits);
        exp_t e;
        waits     = 0;
        req_valid = 1'b1;
        req_re    = re;
        req_we    = we;
        req_adr   = adr;
        req_wdat  = wdat;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req_ready 0 required 1 within 50 cycles");
        end else begin
            check("ram_re", 64'(ram_re), 64'(re));
            check("ram_we", 64'(ram_we), 64'(re ? 4'h0 : we));
            check("ram_adr", 64'(ram_adr), 64'(adr));
            check("ram_wdat", 64'(ram_wdat), 64'(wdat));
            if (re) begin
                e.data = exp_data;
                e.due  = timed ? cyc + 2 : -1;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_re    = 1'b0;
        req_we    = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_sweep(input int i);
        @(negedge clk);
        check("sweep_we", 64'(ram_we), 64'(4'hF));
        check("sweep_adr", 64'(ram_adr), 64'(i));
        check("sweep_wdat", 64'(ram_wdat), 64'(0));
        check("sweep_req_ready", 64'(req_ready), 64'(0));
        check("sweep_init_done", 64'(init_done), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_re    = 1'b0;
        req_we    = '0;
        req_adr   = '0;
        req_wdat  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdat", 64'(rsp_rdat), 64'(0));
        check("rst_ram_re", 64'(ram_re), 64'(0));
        check("rst_ram_we", 64'(ram_we), 64'(0));
        check("rst_ram_adr", 64'(ram_adr), 64'(0));
        check("rst_ram_wdat", 64'(ram_wdat), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) check_sweep(i);
        @(negedge clk);
        check("init_done", 64'(init_done), 64'(1));
        check("run_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;

        // Byte-strobed write then immediate read-back of the same word.
        send(1'b0, 4'b0101, 4'd3, 32'hA5A5_1234, 32'h0, 1'b0, w);
        send(1'b1, 4'b0000, 4'd3, 32'h0, 32'h00A5_0034, 1'b1, w);
        wait_drain();

        for (int i = 0; i < 8; i++)
            send(1'b0, 4'hF, 4'(i), 32'hC0DE_0000 | 32'(i), 32'h0, 1'b0, w);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 4'h0, 4'(i), 32'h0, 32'hC0DE_0000 | 32'(i), 1'b1, w);
            check("b2b_waits", 64'(w), 64'(0));
        end
        wait_drain();

        rsp_ready = 1'b0;
        send(1'b1, 4'h0, 4'd1, 32'h0, 32'hC0DE_0001, 1'b0, w);
        check("bp_first_waits", 64'(w), 64'(0));
        send(1'b1, 4'h0, 4'd2, 32'h0, 32'hC0DE_0002, 1'b0, w);
        check("bp_second_waits", 64'(w), 64'(0));
        req_valid = 1'b1;
        req_re    = 1'b1;
        req_adr   = 4'd3;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall", 64'(req_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_re    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_same_cycle", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        wait_drain();

        send(1'b1, 4'hF, 4'd5, 32'hFFFF_FFFF, 32'hC0DE_0005, 1'b1, w);
        send(1'b1, 4'h0, 4'd5, 32'h0, 32'hC0DE_0005, 1'b1, w);
        wait_drain();

        send(1'b0, 4'h0, 4'd6, 32'h1234_5678, 32'h0, 1'b0, w);
        send(1'b1, 4'h0, 4'd6, 32'h0, 32'hC0DE_0006, 1'b1, w);
        wait_drain();

        rsp_ready = 1'b0;
        send(1'b1, 4'h0, 4'd1, 32'h0, 32'hC0DE_0001, 1'b0, w);
        send(1'b1, 4'h0, 4'd2, 32'h0, 32'hC0DE_0002, 1'b0, w);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pend_rsp_valid", 64'(rsp_valid), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_ram_re", 64'(ram_re), 64'(0));
        check("midrst_ram_we", 64'(ram_we), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        check("midrst_init_done", 64'(init_done), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rsp_dropped", 64'(rsp_valid), 64'(0));
        check("resweep_we", 64'(ram_we), 64'(4'hF));
        check("resweep_adr", 64'(ram_adr), 64'(0));
        for (int i = 1; i < 16; i++) check_sweep(i);
        @(negedge clk);
        check("reinit_done", 64'(init_done), 64'(1));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("no_stale_rsp", 64'(rsp_valid), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
